// File: rtl/lane_mac_pkg.sv
// lane_mac_pkg: shared FSM encoding and widths for lane_mac_ram and its lanes.
package lane_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int         SHORT_W    = 16;
    localparam int         PAIR_W     = 32;
    localparam int         PIPE_DEPTH = 3;
    localparam logic [9:0] LED_RESET  = 10'h3FF;

endpackage

// File: rtl/lane_mac_unit.sv
// lane_mac_unit: one MAC lane -- registered signed 16x16 product feeding a
// signed accumulator. Optional macro LANE_MAC_SATURATE_EN clamps the
// accumulator at its signed bounds and reports each clamp on 'sat'.
module lane_mac_unit
    import lane_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [PAIR_W-1:0]    pair,
`ifdef LANE_MAC_SATURATE_EN
    output logic                 sat,
`endif
    output logic [ACC_WIDTH-1:0] acc
);

    // Sum is wide enough for either operand plus a carry, so it never wraps
    // before the wrap/clamp decision is taken.
    localparam int SUM_W = ((ACC_WIDTH > PAIR_W) ? ACC_WIDTH : PAIR_W) + 1;

    logic signed [SHORT_W-1:0]   a;
    logic signed [SHORT_W-1:0]   b;
    logic signed [PAIR_W-1:0]    prod_q;
    logic                        prod_valid;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [SUM_W-1:0]     sum;

    assign a   = pair[SHORT_W-1:0];
    assign b   = pair[PAIR_W-1:SHORT_W];
    assign sum = SUM_W'(acc_q) + SUM_W'(prod_q);
    assign acc = acc_q;

`ifdef LANE_MAC_SATURATE_EN
    localparam logic signed [SUM_W-1:0] ACC_MAX =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

    logic clamp;

    // Next accumulator value, clamped to the signed range
    always_comb begin
        acc_next = sum[ACC_WIDTH-1:0];
        clamp    = 1'b0;
        if (sum > ACC_MAX) begin
            acc_next = ACC_MAX[ACC_WIDTH-1:0];
            clamp    = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_next = ACC_MIN[ACC_WIDTH-1:0];
            clamp    = 1'b1;
        end
    end

    // One-cycle pulse whenever an accumulate step had to clamp
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat <= 1'b0;
        end else begin
            sat <= prod_valid & clamp & ~clear;
        end
    end
`else
    // Next accumulator value, two's complement wrap
    always_comb begin
        acc_next = sum[ACC_WIDTH-1:0];
    end
`endif

    // Multiply stage: register the signed product and its valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q     <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_q     <= PAIR_W'(a) * PAIR_W'(b);
            prod_valid <= in_valid;
        end
    end

    // Accumulate stage: clear on a new run, otherwise add valid products
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (prod_valid) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/lane_mac_ram.sv
// lane_mac_ram: host-accessible scratch RAM of LANES short pairs per word,
// with a compute port that streams a word range through LANES MAC lanes.
// Optional macro LANE_MAC_SATURATE_EN turns on accumulator saturation and
// repurposes leds[7] as a sticky saturation flag.
module lane_mac_ram
    import lane_mac_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [LANES*PAIR_W-1:0]    wr_data,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic [LANES*PAIR_W-1:0]    rd_data,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH:0]        length,
    output logic                       busy,
    output logic                       done,
    output logic [LANES*ACC_WIDTH-1:0] acc_out,
    output logic [9:0]                 leds,
    output logic [31:0]                hex0
);

    localparam int WORD_W = LANES * PAIR_W;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [WORD_W-1:0]     c_rdata;
    logic                  c_valid;
    logic [ADDR_WIDTH-1:0] c_addr;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      idx;
    logic [1:0]            drain_cnt;
    logic                  accept;
    logic                  issue;

    logic                  led_busy;
    logic                  led_done;
    logic [7:0]            led_addr;
    logic signed [ACC_WIDTH-1:0] acc0;

    // Compute address wraps naturally at the top of the address space
    assign c_addr = base_q + idx[ADDR_WIDTH-1:0];
    assign acc0   = acc_out[ACC_WIDTH-1:0];

    // RAM write port and compute read port; reads see the pre-write word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        c_rdata <= mem[c_addr];
    end

    // Registered host read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (length == '0) ? DONE : RUN;
            RUN:     if (idx == len_q - CNT_W'(1)) next_state = DRAIN;
            DRAIN:   if (drain_cnt == 2'(PIPE_DEPTH - 2)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs and control strobes
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        issue  = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE:  accept = start;
            RUN: begin
                busy  = 1'b1;
                issue = 1'b1;
            end
            DRAIN: busy = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Run bookkeeping: captured range, read index, drain counter, read valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            len_q     <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            c_valid   <= 1'b0;
        end else begin
            if (accept) begin
                base_q <= base_addr;
                len_q  <= length;
                idx    <= '0;
            end else if (issue) begin
                idx <= idx + CNT_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
            c_valid   <= issue;
        end
    end

`ifdef LANE_MAC_SATURATE_EN
    logic [LANES-1:0] sat_vec;
    logic             led_sat;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_mac_unit #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_unit (
            .clk      (clk),
            .reset    (reset),
            .clear    (accept),
            .in_valid (c_valid),
            .pair     (c_rdata[PAIR_W*k +: PAIR_W]),
`ifdef LANE_MAC_SATURATE_EN
            .sat      (sat_vec[k]),
`endif
            .acc      (acc_out[ACC_WIDTH*k +: ACC_WIDTH])
        );
    end

    // Status outputs; led_busy tracks next_state so it matches busy after each edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_busy <= LED_RESET[9];
            led_done <= LED_RESET[8];
            led_addr <= LED_RESET[7:0];
            hex0     <= '0;
        end else begin
            led_busy <= (next_state == RUN) || (next_state == DRAIN);
            if (next_state == DONE) begin
                led_done <= 1'b1;
            end else if (accept) begin
                led_done <= 1'b0;
            end
            if (wr_en) begin
                led_addr <= 8'(wr_addr);
            end
            if (done) begin
                hex0 <= 32'(acc0);
            end
        end
    end

`ifdef LANE_MAC_SATURATE_EN
    // Sticky saturation flag, cleared by an accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_sat <= LED_RESET[7];
        end else if (accept) begin
            led_sat <= 1'b0;
        end else if (|sat_vec) begin
            led_sat <= 1'b1;
        end
    end

    assign leds = {led_busy, led_done, led_sat, led_addr[6:0]};
`else
    assign leds = {led_busy, led_done, led_addr};
`endif

endmodule
